// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin type codes
// and the default denomination set.
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DISPENSE = 2'd2
  } state_t;

  localparam logic [1:0] COIN_TYPE_C = 2'd0;
  localparam logic [1:0] COIN_TYPE_B = 2'd1;
  localparam logic [1:0] COIN_TYPE_A = 2'd2;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_COIN_A = 5;
  localparam int DEF_COIN_B = 2;
  localparam int DEF_COIN_C = 1;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest denomination whose value does not exceed the change owed.
// With zero change owed it falls back to the smallest coin, which is never transferred.
module coin_select
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int COIN_A = DEF_COIN_A,
  parameter int COIN_B = DEF_COIN_B,
  parameter int COIN_C = DEF_COIN_C
) (
  input  logic [WIDTH-1:0] i_change_left,
  output logic [1:0]       o_coin_type,
  output logic [WIDTH-1:0] o_coin_value
);

  localparam logic [WIDTH-1:0] VAL_A = WIDTH'(COIN_A);
  localparam logic [WIDTH-1:0] VAL_B = WIDTH'(COIN_B);
  localparam logic [WIDTH-1:0] VAL_C = WIDTH'(COIN_C);

  always_comb begin
    o_coin_type  = COIN_TYPE_C;
    o_coin_value = VAL_C;
    if (i_change_left >= VAL_A) begin
      o_coin_type  = COIN_TYPE_A;
      o_coin_value = VAL_A;
    end else if (i_change_left >= VAL_B) begin
      o_coin_type  = COIN_TYPE_B;
      o_coin_value = VAL_B;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Latches credit and price on start, rejects underpayment, then pays change one coin
// per valid/ready handshake, largest coin first.
//
// state       | meaning
// ST_IDLE     | waiting for start; inputs latched on start
// ST_CHECK    | compare money against price, load change owed
// ST_DISPENSE | present coins until change owed reaches zero
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int COIN_A = DEF_COIN_A,
  parameter int COIN_B = DEF_COIN_B,
  parameter int COIN_C = DEF_COIN_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] moneyEntered,
  input  logic [WIDTH-1:0] price,
  input  logic             coinReady,
  output logic             coinValid,
  output logic [1:0]       coinType,
  output logic [WIDTH-1:0] changeLeft,
  output logic             busy,
  output logic             insufficient,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_money;
  logic [WIDTH-1:0] r_price;
  logic [WIDTH-1:0] r_change_left;
  logic             r_insufficient;
  logic             r_done;

  logic [WIDTH-1:0] w_money_nxt;
  logic [WIDTH-1:0] w_price_nxt;
  logic [WIDTH-1:0] w_change_nxt;
  logic             w_insufficient_nxt;
  logic             w_done_nxt;
  logic [1:0]       w_coin_type;
  logic [WIDTH-1:0] w_coin_value;

  // Coin choice depends only on the registered change, so it cannot move while stalled.
  coin_select #(
    .WIDTH (WIDTH),
    .COIN_A(COIN_A),
    .COIN_B(COIN_B),
    .COIN_C(COIN_C)
  ) u_coin_select (
    .i_change_left(r_change_left),
    .o_coin_type  (w_coin_type),
    .o_coin_value (w_coin_value)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_money        <= '0;
      r_price        <= '0;
      r_change_left  <= '0;
      r_insufficient <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_money        <= w_money_nxt;
      r_price        <= w_price_nxt;
      r_change_left  <= w_change_nxt;
      r_insufficient <= w_insufficient_nxt;
      r_done         <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_money_nxt        = r_money;
    w_price_nxt        = r_price;
    w_change_nxt       = r_change_left;
    w_insufficient_nxt = 1'b0;
    w_done_nxt         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_money_nxt = moneyEntered;
          w_price_nxt = price;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_money < r_price) begin
          w_insufficient_nxt = 1'b1;
          w_state_nxt        = ST_IDLE;
        end else begin
          w_change_nxt = r_money - r_price;
          if (r_money == r_price) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DISPENSE;
          end
        end
      end
      ST_DISPENSE: begin
        // The smallest coin is 1, so the chosen coin never exceeds the change owed.
        if (coinReady) begin
          w_change_nxt = r_change_left - w_coin_value;
          if (r_change_left == w_coin_value) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign coinValid    = (r_state == ST_DISPENSE);
  assign coinType     = w_coin_type;
  assign changeLeft   = r_change_left;
  assign busy         = (r_state != ST_IDLE);
  assign insufficient = r_insufficient;
  assign done         = r_done;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised bench for change_dispenser with a reference model that derives the coin
// list from division/remainder on the change owed.
module tb_change_dispenser;

  localparam int WIDTH  = 5;
  localparam int COIN_A = 5;
  localparam int COIN_B = 2;
  localparam int COIN_C = 1;
  localparam int MAXV   = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] moneyEntered;
  logic [WIDTH-1:0] price;
  logic             coinReady;
  logic             coinValid;
  logic [1:0]       coinType;
  logic [WIDTH-1:0] changeLeft;
  logic             busy;
  logic             insufficient;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  change_dispenser #(
    .WIDTH (WIDTH),
    .COIN_A(COIN_A),
    .COIN_B(COIN_B),
    .COIN_C(COIN_C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .moneyEntered(moneyEntered),
    .price       (price),
    .coinReady   (coinReady),
    .coinValid   (coinValid),
    .coinType    (coinType),
    .changeLeft  (changeLeft),
    .busy        (busy),
    .insufficient(insufficient),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int coin_val(input int t);
    return (t == 2) ? COIN_A : (t == 1) ? COIN_B : COIN_C;
  endfunction

  // stall: cycles of coinReady=0 at the start of dispense; rnd: random ready afterwards
  task automatic run_txn(input int m, input int p, input int stall, input bit rnd);
    int exp_q[$];
    int rem, r, cycles, stalls;
    bit rdy;
    rem = m - p;
    if (rem > 0) begin
      r = rem;
      repeat (r / COIN_A) exp_q.push_back(2);
      r = r % COIN_A;
      repeat (r / COIN_B) exp_q.push_back(1);
      r = r % COIN_B;
      repeat (r / COIN_C) exp_q.push_back(0);
    end
    @(negedge clk);
    start = 1'b1; moneyEntered = WIDTH'(m); price = WIDTH'(p); coinReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("check_busy", int'(busy), 1);
    chk("check_novalid", int'(coinValid), 0);
    @(negedge clk);
    if (m < p) begin
      chk("insuf_pulse", int'(insufficient), 1);
      chk("insuf_novalid", int'(coinValid), 0);
      chk("insuf_nodone", int'(done), 0);
      chk("insuf_cl", int'(changeLeft), 0);
      @(negedge clk);
      chk("insuf_end", int'(insufficient), 0);
      chk("insuf_busy", int'(busy), 0);
      return;
    end
    if (rem == 0) begin
      chk("zero_done", int'(done), 1);
      chk("zero_novalid", int'(coinValid), 0);
      chk("zero_cl", int'(changeLeft), 0);
      @(negedge clk);
      chk("zero_done_end", int'(done), 0);
      chk("zero_busy", int'(busy), 0);
      return;
    end
    cycles = 0;
    stalls = stall;
    while (exp_q.size() > 0 && cycles < 200) begin
      chk("disp_valid", int'(coinValid), 1);
      chk("disp_type", int'(coinType), exp_q[0]);
      chk("disp_cl", int'(changeLeft), rem);
      chk("disp_busy", int'(busy), 1);
      chk("disp_nodone", int'(done), 0);
      if (stalls > 0) begin
        rdy = 1'b0;
        stalls--;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      coinReady = rdy;
      // start during dispense must be ignored
      start = ($urandom_range(0, 3) == 0);
      moneyEntered = WIDTH'($urandom_range(0, MAXV));
      price = WIDTH'($urandom_range(0, MAXV));
      @(negedge clk);
      cycles++;
      if (rdy) begin
        rem -= coin_val(exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    coinReady = 1'b0;
    start = 1'b0;
    chk("disp_timeout", int'(cycles < 200), 1);
    chk("end_done", int'(done), 1);
    chk("end_novalid", int'(coinValid), 0);
    chk("end_cl", int'(changeLeft), 0);
    chk("end_busy", int'(busy), 0);
    @(negedge clk);
    chk("end_done_pulse", int'(done), 0);
    chk("end_idle", int'(busy), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; moneyEntered = '0; price = '0; coinReady = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(coinValid), 0);
    chk("rst_type", int'(coinType), 0);
    chk("rst_cl", int'(changeLeft), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_insuf", int'(insufficient), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(20, 2, 0, 1'b0);
    run_txn(7, 7, 0, 1'b0);
    run_txn(3, 9, 0, 1'b0);
    run_txn(9, 0, 4, 1'b0);
    run_txn(MAXV, 0, 0, 1'b0);
    run_txn(MAXV, 0, 2, 1'b1);

    // reset in the middle of a payout
    @(negedge clk);
    start = 1'b1; moneyEntered = 5'd20; price = 5'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    coinReady = 1'b1;
    n = 0;
    while (changeLeft != 5'd8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    coinReady = 1'b0;
    chk("mid_cl", int'(changeLeft), 8);
    start = 1'b1; moneyEntered = 5'd31; price = 5'd0;
    @(negedge clk);
    start = 1'b0;
    chk("mid_start_ignored_cl", int'(changeLeft), 8);
    chk("mid_type", int'(coinType), 2);
    chk("mid_valid", int'(coinValid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", int'(coinValid), 0);
    chk("abort_cl", int'(changeLeft), 0);
    chk("abort_type", int'(coinType), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_insuf", int'(insufficient), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", int'(busy), 0);
    run_txn(12, 1, 0, 1'b0);

    repeat (40) begin
      run_txn($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, 3), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
